// File: rtl/btn_event.sv
// btn_event: per-button press/release/long/auto-repeat events plus two-button combo detection
module btn_event #(
   parameter int LONG_TICKS   = 500,
   parameter int REPEAT_TICKS = 100
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic [1:0] btn,
   output logic [1:0] press_pulse,
   output logic [1:0] release_pulse,
   output logic [1:0] long_pulse,
   output logic [1:0] repeat_pulse,
   output logic [1:0] held,
   output logic       combo_pulse
);
   typedef enum logic [1:0] {IDLE, HOLD, RPT} state_t;
   localparam logic [15:0] LONG_MAX = 16'(LONG_TICKS);
   localparam logic [15:0] REP_MAX  = 16'(REPEAT_TICKS);
   state_t      state [2];
   state_t      state_n [2];
   logic [15:0] cnt [2];
   logic [15:0] cnt_n [2];
   logic [1:0]  btn_q, pe, re, press_n, release_n, long_n, repeat_n;
   logic        lock, lock_n, combo_n, mute;
   assign pe      = btn & ~btn_q;
   assign re      = ~btn & btn_q;
   assign combo_n = &btn & |pe;
   // a combo detected this cycle already mutes long/repeat, before the lock register catches up
   assign mute    = lock | combo_n;
   assign lock_n  = ~|btn ? 1'b0 : (lock | combo_n);
   assign held    = {state[1] != IDLE, state[0] != IDLE};
   // per-button hold FSM: next state, counter and event pulses; a release beats a coincident terminal tick
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         state_n[i]   = state[i];
         cnt_n[i]     = cnt[i];
         press_n[i]   = 1'b0;
         release_n[i] = 1'b0;
         long_n[i]    = 1'b0;
         repeat_n[i]  = 1'b0;
         if (state[i] == IDLE) begin
            if (pe[i]) begin
               state_n[i] = HOLD;
               cnt_n[i]   = '0;
               press_n[i] = 1'b1;
            end
         end else if (re[i]) begin
            state_n[i]   = IDLE;
            cnt_n[i]     = '0;
            release_n[i] = 1'b1;
         end else if (tick) begin
            if (cnt[i] + 16'd1 == ((state[i] == HOLD) ? LONG_MAX : REP_MAX)) begin
               state_n[i]  = RPT;
               cnt_n[i]    = '0;
               long_n[i]   = (state[i] == HOLD) & ~mute;
               repeat_n[i] = (state[i] == RPT) & ~mute;
            end else begin
               cnt_n[i] = cnt[i] + 16'd1;
            end
         end
      end
   end
   // state, counters, edge history, combo lock and registered pulse outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         btn_q         <= '0;
         lock          <= 1'b0;
         press_pulse   <= '0;
         release_pulse <= '0;
         long_pulse    <= '0;
         repeat_pulse  <= '0;
         combo_pulse   <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            state[i] <= IDLE;
            cnt[i]   <= '0;
         end
      end else begin
         btn_q         <= btn;
         lock          <= lock_n;
         press_pulse   <= press_n;
         release_pulse <= release_n;
         long_pulse    <= long_n;
         repeat_pulse  <= repeat_n;
         combo_pulse   <= combo_n;
         for (int i = 0; i < 2; i++) begin
            state[i] <= state_n[i];
            cnt[i]   <= cnt_n[i];
         end
      end
   end
endmodule

// File: tb/tb_btn_event.sv
// tb_btn_event: directed scenarios for btn_event with a queue of expected event counts
module tb_btn_event;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick = 1'b0;
   logic [1:0] btn = 2'b00;
   logic [1:0] press_pulse, release_pulse, long_pulse, repeat_pulse, held;
   logic       combo_pulse;
   int errors = 0;
   int checks = 0;
   int n_ticks, n_combo, n_nonzero;
   int n_press [2];
   int n_rel [2];
   int n_long [2];
   int n_rep [2];
   int n_held [2];
   int long_mask [2];
   int rep_mask [2];
   int exp_q [$];

   btn_event #(.LONG_TICKS(5), .REPEAT_TICKS(2)) dut (
      .clk(clk), .rst(rst), .tick(tick), .btn(btn),
      .press_pulse(press_pulse), .release_pulse(release_pulse),
      .long_pulse(long_pulse), .repeat_pulse(repeat_pulse),
      .held(held), .combo_pulse(combo_pulse)
   );

   always #5 clk = ~clk;

   task automatic clear_obs();
      n_ticks = 0;
      n_combo = 0;
      n_nonzero = 0;
      for (int i = 0; i < 2; i++) begin
         n_press[i] = 0; n_rel[i] = 0; n_long[i] = 0; n_rep[i] = 0;
         n_held[i] = 0; long_mask[i] = 0; rep_mask[i] = 0;
      end
   endtask

   task automatic cyc(input logic t);
      tick = t;
      @(posedge clk);
      #1;
      tick = 1'b0;
      if (t) n_ticks++;
      for (int i = 0; i < 2; i++) begin
         if (press_pulse[i] === 1'b1) n_press[i]++;
         if (release_pulse[i] === 1'b1) n_rel[i]++;
         if (long_pulse[i] === 1'b1) begin n_long[i]++; long_mask[i] |= 1 << n_ticks; end
         if (repeat_pulse[i] === 1'b1) begin n_rep[i]++; rep_mask[i] |= 1 << n_ticks; end
         if (held[i] === 1'b1) n_held[i]++;
      end
      if (combo_pulse === 1'b1) n_combo++;
      if ({press_pulse, release_pulse, long_pulse, repeat_pulse, held, combo_pulse} !== 11'd0) n_nonzero++;
   endtask

   task automatic run_ticks(input int n);
      repeat (n) begin
         repeat (3) cyc(1'b0);
         cyc(1'b1);
      end
   endtask

   task automatic expect_v(input int v);
      exp_q.push_back(v);
   endtask

   task automatic check(input string tag, input int obs);
      int e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL %s: observed %0d, no expected value queued", tag, obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, e);
         end
      end
   endtask

   initial begin
      clear_obs();
      rst = 1'b1;
      cyc(1'b0);
      cyc(1'b0);
      expect_v(0);
      check("reset_outputs", n_nonzero);
      rst = 1'b0;

      clear_obs();
      expect_v(1); expect_v(1); expect_v(0); expect_v(12); expect_v(0); expect_v(0);
      btn = 2'b01;
      run_ticks(3);
      btn = 2'b00;
      cyc(1'b0);
      run_ticks(2);
      check("short_press0", n_press[0]);
      check("short_release0", n_rel[0]);
      check("short_long0", n_long[0]);
      check("short_held0_cycles", n_held[0]);
      check("short_press1", n_press[1]);
      check("short_combo", n_combo);

      clear_obs();
      expect_v(32); expect_v(2688); expect_v(3); expect_v(1); expect_v(44); expect_v(0);
      btn = 2'b01;
      run_ticks(11);
      btn = 2'b00;
      cyc(1'b0);
      cyc(1'b0);
      check("long_tick_mask0", long_mask[0]);
      check("repeat_tick_mask0", rep_mask[0]);
      check("repeat_count0", n_rep[0]);
      check("long_release0", n_rel[0]);
      check("long_held0_cycles", n_held[0]);
      check("long_held_final", int'(held));

      clear_obs();
      expect_v(1); expect_v(1); expect_v(1); expect_v(0); expect_v(1); expect_v(0); expect_v(1);
      btn = 2'b11;
      run_ticks(20);
      check("combo_press0", n_press[0]);
      check("combo_press1", n_press[1]);
      check("combo_count", n_combo);
      check("combo_long_rep_both", n_long[0] + n_long[1] + n_rep[0] + n_rep[1]);
      btn = 2'b01;
      run_ticks(10);
      check("combo_release1", n_rel[1]);
      check("combo_after_release1_long_rep", n_long[0] + n_rep[0]);
      btn = 2'b00;
      cyc(1'b0);
      cyc(1'b0);
      check("combo_release0", n_rel[0]);

      clear_obs();
      expect_v(1); expect_v(1); expect_v(0); expect_v(5);
      btn = 2'b01;
      run_ticks(4);
      repeat (3) cyc(1'b0);
      btn = 2'b00;
      cyc(1'b1);
      cyc(1'b0);
      check("race_press0", n_press[0]);
      check("race_release0", n_rel[0]);
      check("race_long0", n_long[0]);
      check("race_ticks", n_ticks);

      clear_obs();
      expect_v(1); expect_v(0); expect_v(1); expect_v(32); expect_v(0); expect_v(1);
      btn = 2'b10;
      run_ticks(6);
      check("rst_pre_long1", n_long[1]);
      clear_obs();
      rst = 1'b1;
      cyc(1'b0);
      cyc(1'b0);
      check("rst_outputs_during_reset", n_nonzero);
      rst = 1'b0;
      cyc(1'b0);
      check("rst_press1_after_release", n_press[1]);
      run_ticks(5);
      check("rst_long_tick_mask1", long_mask[1]);
      check("rst_no_release1", n_rel[1]);
      btn = 2'b00;
      cyc(1'b0);
      check("rst_final_release1", n_rel[1]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
